pagerank_gather: RTL
====================

Name: pagerank_gather

Overview:
- Stage directly downstream of pagerank_scatter.
- Consumes the per-edge contribution stream (node_id, pagerank_scatter_op, output_ready) and accumulates contributions per destination node in a register array.
- When scatter signals operation_complete, applies damping, new_pr = base_term + d * sum, to every node and streams out the new page-rank vector one node per cycle.
- Numeric format everywhere: unsigned Q32.32 in 64 bits.

Parameters:
- NODES_IN_GRAPH, 4, number of accumulator entries; valid node ids are 1..NODES_IN_GRAPH.
- DAMPING_Q, 32'hD999_999A, damping factor d in unsigned Q0.32 (0.85).
- DROP_CNT_W, 16, width of the dropped-update counter.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: clear accumulators, enter ACCUM.
- base_term  in  64  (1-d)/N in Q32.32, supplied by software; sampled during APPLY.
- update_valid  in  1  connects to scatter output_ready.
- update_node_id  in  32  connects to scatter node_id.
- update_value  in  64  connects to scatter pagerank_scatter_op (Q32.32).
- scatter_done  in  1  connects to scatter operation_complete.
- pr_valid  out  1  new page-rank word valid.
- pr_node_id  out  32  node id of pr_value (1-based).
- pr_value  out  64  new page rank, Q32.32.
- iteration_done  out  1  one-cycle pulse after the last pr_valid.
- busy  out  1  high in ACCUM, APPLY and DONE.
- dropped_count  out  DROP_CNT_W  saturating count of discarded updates.

Behaviour:
- Reset: state IDLE; all outputs 0; accumulators 0; dropped_count 0. Reset has priority over every other input, including mid-ACCUM and mid-APPLY.
- States: IDLE, ACCUM, APPLY, DONE.
- IDLE -> ACCUM on start.
- ACCUM -> APPLY on scatter_done.
- APPLY -> DONE after node NODES_IN_GRAPH is emitted.
- DONE -> IDLE unconditionally after 1 cycle.
- start in any non-reset state:
  - clears all accumulators, deasserts pr_valid, enters ACCUM.
  - An update_valid in the same cycle is written into the cleared entry (acc = update_value), not dropped.
- ACCUM, per update_valid: idx = update_node_id - 1; acc[idx] <= acc[idx] + update_value. One update per cycle, no backpressure, no hazard (flop array).
- Updates that are dropped, each incrementing dropped_count (saturating at all-ones):
  - update_node_id of 0 (scatter padding) or greater than NODES_IN_GRAPH.
  - update_valid in IDLE, APPLY or DONE.
- Addition wraps mod 2^64 unless the optional feature is enabled.
- scatter_done with update_valid in the same cycle: the update is accumulated first, then the state moves to APPLY.
- APPLY: let T be the cycle in which scatter_done is sampled.
  - For k = 1..N, on cycle T+k: pr_valid=1, pr_node_id=k, pr_value = base_term + ((acc[k-1] * DAMPING_Q) >> 32).
  - Product is 96 bits; the low 64 bits after the shift are kept.
  - The final add wraps mod 2^64.
  - Outputs are registered.
- DONE: iteration_done=1 on cycle T+N+1; pr_valid=0. Accumulators are retained until the next start.
- busy = (state != IDLE).

Optional Feature:
- Macro: PAGERANK_GATHER_SATURATE_EN.
- Defined: the accumulator add and the final base_term add saturate at 64'hFFFF_FFFF_FFFF_FFFF.
- Undefined: both adds wrap mod 2^64.
- No other behaviour changes.

Test Plan:
- Reset during ACCUM after 2 updates:
  - next cycle all outputs 0, state IDLE.
  - start then scatter_done with no updates gives pr_value = base_term for all nodes.
- Basic damping (N=4, base_term=64'h0999_999A):
  - start; updates (2, 64'h4000_0000), (2, 64'h4000_0000); scatter_done.
  - 4 consecutive pr_valid cycles with ids 1..4.
  - node 2 = 64'h7666_6667; nodes 1, 3, 4 = 64'h0999_999A.
  - iteration_done on the following cycle.
- Padding and range:
  - updates with node_id 0 and 5 (N=4): accumulators unchanged, dropped_count = 2.
  - an update during APPLY brings dropped_count to 3.
- Simultaneous events:
  - update (3, 64'h8000_0000) in the same cycle as scatter_done: node 3 = 64'h0999_999A + 64'h6CCC_CCCD = 64'h7666_6667.
  - start with update (1, 64'h4000_0000) in the same cycle: acc[0] = 64'h4000_0000.
- Restart mid-APPLY: start on the 2nd pr_valid cycle -> pr_valid drops the next cycle, no iteration_done, accumulators zero.
- Overflow: updates (1, 64'hFFFF_FFFF_0000_0000) and (1, 64'h0000_0002_0000_0000).
  - Without macro: acc = 64'h0000_0001_0000_0000.
  - With PAGERANK_GATHER_SATURATE_EN: acc = all-ones.

Source files
------------

// File: rtl/pagerank_gather.sv
// rtl/pagerank_gather.sv - per-node accumulate of scatter contributions, then damped page-rank stream-out
// Optional PAGERANK_GATHER_SATURATE_EN: accumulator and base_term adds saturate instead of wrapping.
module pagerank_gather #(
    parameter int          NODES_IN_GRAPH = 4,
    parameter logic [31:0] DAMPING_Q      = 32'hD999_999A,
    parameter int          DROP_CNT_W     = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [63:0]           base_term,
    input  logic                  update_valid,
    input  logic [31:0]           update_node_id,
    input  logic [63:0]           update_value,
    input  logic                  scatter_done,
    output logic                  pr_valid,
    output logic [31:0]           pr_node_id,
    output logic [63:0]           pr_value,
    output logic                  iteration_done,
    output logic                  busy,
    output logic [DROP_CNT_W-1:0] dropped_count
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_APPLY, S_DONE} state_t;

    state_t      state, state_next;
    logic [31:0] apply_cnt, apply_cnt_next;
    logic [63:0] acc      [NODES_IN_GRAPH];
    logic [63:0] acc_next [NODES_IN_GRAPH];
    logic        id_ok, accept, drop;
    logic        emit, done_next;
    logic [31:0] emit_id;
    logic [63:0] emit_acc, emit_value;
    logic [95:0] product;

    function automatic logic [63:0] add64(input logic [63:0] a, input logic [63:0] b);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef PAGERANK_GATHER_SATURATE_EN
        return s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
`else
        return s[63:0];
`endif
    endfunction

    // Accumulator next-state: a start clears every entry, and a same-cycle update lands on the cleared value.
    always_comb begin
        id_ok  = (update_node_id != 32'd0) && (update_node_id <= 32'(NODES_IN_GRAPH));
        accept = update_valid && id_ok && (start || state == S_ACCUM);
        drop   = update_valid && !accept;
        for (int i = 0; i < NODES_IN_GRAPH; i++) begin
            acc_next[i] = start ? 64'd0 : acc[i];
            if (accept && update_node_id == 32'(i + 1))
                acc_next[i] = add64(acc_next[i], update_value);
        end
    end

    always_comb begin
        state_next     = state;
        apply_cnt_next = apply_cnt;
        emit           = 1'b0;
        emit_id        = 32'd0;
        done_next      = 1'b0;
        if (start) begin
            state_next = S_ACCUM;
        end else begin
            case (state)
                S_IDLE: ;
                S_ACCUM: begin
                    if (scatter_done) begin
                        state_next     = S_APPLY;
                        emit           = 1'b1;
                        emit_id        = 32'd1;
                        apply_cnt_next = 32'd1;
                    end
                end
                S_APPLY: begin
                    if (apply_cnt < 32'(NODES_IN_GRAPH)) begin
                        emit           = 1'b1;
                        emit_id        = apply_cnt + 32'd1;
                        apply_cnt_next = apply_cnt + 32'd1;
                    end else begin
                        state_next = S_DONE;
                        done_next  = 1'b1;
                    end
                end
                S_DONE: state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Node 1 is computed in the scatter_done cycle, so it reads the post-update accumulator value.
    always_comb begin
        emit_acc = 64'd0;
        for (int i = 0; i < NODES_IN_GRAPH; i++) begin
            if (emit_id == 32'(i + 1))
                emit_acc = acc_next[i];
        end
        product    = {32'd0, emit_acc} * {64'd0, DAMPING_Q};
        emit_value = add64(base_term, product[95:32]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            apply_cnt      <= 32'd0;
            pr_valid       <= 1'b0;
            pr_node_id     <= 32'd0;
            pr_value       <= 64'd0;
            iteration_done <= 1'b0;
            dropped_count  <= '0;
            for (int i = 0; i < NODES_IN_GRAPH; i++)
                acc[i] <= 64'd0;
        end else begin
            state          <= state_next;
            apply_cnt      <= apply_cnt_next;
            pr_valid       <= emit;
            pr_node_id     <= emit ? emit_id : 32'd0;
            pr_value       <= emit ? emit_value : 64'd0;
            iteration_done <= done_next;
            if (drop && dropped_count != {DROP_CNT_W{1'b1}})
                dropped_count <= dropped_count + DROP_CNT_W'(1);
            for (int i = 0; i < NODES_IN_GRAPH; i++)
                acc[i] <= acc_next[i];
        end
    end

    assign busy = (state != S_IDLE);

endmodule
